irrigation_ctrl: RTL and testbench
==================================

Name: irrigation_ctrl

Overview:
Decision stage directly upstream of the servo PWM generator. Takes the raw rain sensor and soil-moisture inputs, synchronises and debounces them, and runs a valve-control FSM. Drives `angle_sel` for the PWM stage: 0 = valve open (0°), 1 = valve closed (90°). Enforces a maximum watering time, a cooldown between watering runs, and a rain lockout hold time. Rain always overrides watering.

Parameters:
- DEBOUNCE_CYCLES, 500_000: cycles a synchronised input must be stable before the debounced value updates (10 ms at 50 MHz).
- MAX_WATER_CYCLES, 1_500_000_000: maximum continuous valve-open time (30 s).
- COOLDOWN_CYCLES, 250_000_000: valve-closed time after a watering run before another may start (5 s).
- RAIN_HOLD_CYCLES, 500_000_000: valve-closed time after rain clears (10 s).
- CNT_W, 32: width of the shared state timer. It must hold max(MAX_WATER, COOLDOWN, RAIN_HOLD) - 1.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- rain_raw  in  1  asynchronous rain sensor; 1 = rain.
- soil_dry_raw  in  1  asynchronous soil sensor; 1 = dry.
- angle_sel  out  1  servo command to the PWM stage; 0 = open, 1 = closed.
- watering  out  1  high while in WATERING.
- rain_det  out  1  debounced rain level.
- state  out  2  FSM state: 00 IDLE, 01 WATERING, 10 RAIN_HOLD, 11 COOLDOWN.
- timeout_pulse  out  1  single-cycle pulse when a watering run ends on MAX_WATER_CYCLES.

Behaviour:
- Reset (asynchronous, reset_n = 0) forces:
  - state = IDLE, angle_sel = 1 (safe/closed).
  - watering = 0, rain_det = 0, timeout_pulse = 0.
  - Synchroniser flops = 0, debounce counters = 0, timer = 0.
  - If reset is asserted mid-watering, the valve closes immediately (asynchronously).
- Synchronisation: each raw input passes through a 2-flop synchroniser. The synchronised value is called s.
- Debounce, per input, with an independent counter:
  - If s == db, the counter clears to 0.
  - Otherwise the counter increments. When counter == DEBOUNCE_CYCLES-1 and s != db, db <= s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
  - Latency: raw edge first sampled at edge 1 -> db updates at edge 2+DEBOUNCE_CYCLES -> state and angle_sel update at edge 3+DEBOUNCE_CYCLES.
- All outputs are registered. angle_sel, watering and state update on the same edge as the state register. rain_det = rain db.
- Timer: clears to 0 on every state transition and increments by 1 each cycle otherwise, except as stated below.
- FSM transitions, evaluated each cycle, priority top-down:
  - IDLE:
    - rain_db -> RAIN_HOLD.
    - else dry_db -> WATERING.
    - else stay.
  - WATERING (angle_sel = 0, watering = 1):
    - rain_db -> RAIN_HOLD.
    - else !dry_db -> COOLDOWN.
    - else timer == MAX_WATER_CYCLES-1 -> COOLDOWN, with timeout_pulse = 1 for exactly that one cycle (registered with the transition).
    - The valve is therefore open for at most MAX_WATER_CYCLES cycles.
  - RAIN_HOLD:
    - While rain_db = 1, the timer is held at 0.
    - Once rain_db = 0, the timer counts. At timer == RAIN_HOLD_CYCLES-1 -> IDLE.
    - If rain returns mid-count, the timer restarts from 0.
  - COOLDOWN:
    - rain_db -> RAIN_HOLD.
    - else timer == COOLDOWN_CYCLES-1 -> IDLE.
    - The dry input is ignored during cooldown.
- IDLE always lasts at least 1 cycle between runs. A still-dry soil re-enters WATERING on the cycle after returning to IDLE.
- Simultaneous rain and dry in any state: rain wins.
- Timer arithmetic is unsigned, width CNT_W. The timer never wraps, because every counting state exits at its terminal count.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, MAX_WATER_CYCLES=20, COOLDOWN_CYCLES=8, RAIN_HOLD_CYCLES=10.
1. Reset then release, all raw inputs = 0 -> angle_sel=1, state=00, all other outputs 0, held for 50 cycles.
2. Raise soil_dry_raw at edge 1 -> state=01 and angle_sel=0 at edge 7. Drop soil_dry_raw -> state=11 seven edges later. After 8 cycles in COOLDOWN -> state=00.
3. Hold soil dry indefinitely -> angle_sel low for exactly 20 cycles, then timeout_pulse high for 1 cycle as state=11. 8 cycles COOLDOWN, 1 cycle IDLE, then WATERING again.
4. While WATERING, raise rain_raw -> state=10 and angle_sel=1 seven edges later, rain_det=1. Hold 30 cycles, clear rain -> rain_det=0 after debounce, then 10 cycles, then IDLE/WATERING.
5. Pulse rain_raw high for 3 cycles during WATERING -> rain_det stays 0 and angle_sel stays 0.
6. Assert reset_n=0 mid-WATERING, asynchronously between edges -> angle_sel=1 immediately. Release -> IDLE, and WATERING re-entered only after the full debounce latency.

Source files
------------

// File: rtl/irrigation_ctrl.sv
// Valve decision stage ahead of the servo PWM: synchronises and debounces the rain and
// soil sensors, then runs the watering FSM that drives angle_sel (0 = open, 1 = closed).
module irrigation_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 500_000,
    parameter int MAX_WATER_CYCLES = 1_500_000_000,
    parameter int COOLDOWN_CYCLES  = 250_000_000,
    parameter int RAIN_HOLD_CYCLES = 500_000_000,
    parameter int CNT_W            = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rain_raw,
    input  logic       soil_dry_raw,
    output logic       angle_sel,
    output logic       watering,
    output logic       rain_det,
    output logic [1:0] state,
    output logic       timeout_pulse
);

    localparam logic [1:0] S_IDLE      = 2'b00;
    localparam logic [1:0] S_WATERING  = 2'b01;
    localparam logic [1:0] S_RAIN_HOLD = 2'b10;
    localparam logic [1:0] S_COOLDOWN  = 2'b11;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_WATER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RH_LAST  = CNT_W'(RAIN_HOLD_CYCLES - 1);

    // Index 0 = rain, index 1 = soil dry.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            db_q, db_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             angle_sel_q, angle_sel_d;
    logic             watering_q, watering_d;
    logic             timeout_q, timeout_d;

    logic rain_db, dry_db;
    assign rain_db = db_q[0];
    assign dry_db  = db_q[1];

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + CNT_W'(1);
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Idle does not time anything; parking the timer keeps it from wrapping.
                timer_d = '0;
                if (rain_db)     state_d = S_RAIN_HOLD;
                else if (dry_db) state_d = S_WATERING;
            end
            S_WATERING: begin
                if (rain_db)        state_d = S_RAIN_HOLD;
                else if (!dry_db)   state_d = S_COOLDOWN;
                else if (timer_q == MAX_LAST) begin
                    state_d   = S_COOLDOWN;
                    timeout_d = 1'b1;
                end
            end
            S_RAIN_HOLD: begin
                if (rain_db)                 timer_d = '0;
                else if (timer_q == RH_LAST) state_d = S_IDLE;
            end
            S_COOLDOWN: begin
                if (rain_db)                 state_d = S_RAIN_HOLD;
                else if (timer_q == CD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
        angle_sel_d = (state_d != S_WATERING);
        watering_d  = (state_d == S_WATERING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_cnt_q    <= '0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            angle_sel_q <= 1'b1;
            watering_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= {soil_dry_raw, rain_raw};
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            angle_sel_q <= angle_sel_d;
            watering_q  <= watering_d;
            timeout_q   <= timeout_d;
        end
    end

    assign angle_sel     = angle_sel_q;
    assign watering      = watering_q;
    assign rain_det      = rain_db;
    assign state         = state_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Directed bench for irrigation_ctrl with short timing parameters; expected values are
// hand-derived edge counts from the raw input change (edge 1 = first sampling edge).
module tb_irrigation_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rain_raw = 1'b0;
    logic       soil_dry_raw = 1'b0;
    logic       angle_sel, watering, rain_det, timeout_pulse;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    irrigation_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .MAX_WATER_CYCLES(20),
        .COOLDOWN_CYCLES (8),
        .RAIN_HOLD_CYCLES(10),
        .CNT_W           (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rain_raw     (rain_raw),
        .soil_dry_raw (soil_dry_raw),
        .angle_sel    (angle_sel),
        .watering     (watering),
        .rain_det     (rain_det),
        .state        (state),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        total++;
        if ({angle_sel, watering, rain_det, timeout_pulse, state} !== 6'b1000_00) begin
            bad++;
            $display("FAIL reset_hold: got a=%b w=%b r=%b t=%b s=%b want a=1 w=0 r=0 t=0 s=00",
                     angle_sel, watering, rain_det, timeout_pulse, state);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            total++;
            if ({angle_sel, watering, rain_det, timeout_pulse, state} !== 6'b1000_00) begin
                bad++;
                $display("FAIL idle_quiet cyc%0d: got a=%b w=%b r=%b t=%b s=%b want 1,0,0,0,00",
                         i, angle_sel, watering, rain_det, timeout_pulse, state);
            end
        end
    endtask

    task automatic test_water_dry();
        soil_dry_raw = 1'b1;
        step(6);
        total++;
        if (state !== 2'b00 || angle_sel !== 1'b1) begin
            bad++;
            $display("FAIL dry_edge6: got s=%b a=%b want s=00 a=1", state, angle_sel);
        end
        step(1);
        total++;
        if (state !== 2'b01 || angle_sel !== 1'b0 || watering !== 1'b1) begin
            bad++;
            $display("FAIL dry_edge7: got s=%b a=%b w=%b want s=01 a=0 w=1", state, angle_sel, watering);
        end
        soil_dry_raw = 1'b0;
        step(6);
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL wet_edge6: got s=%b want 01", state);
        end
        step(1);
        total++;
        if (state !== 2'b11 || angle_sel !== 1'b1 || timeout_pulse !== 1'b0) begin
            bad++;
            $display("FAIL wet_edge7: got s=%b a=%b t=%b want s=11 a=1 t=0", state, angle_sel, timeout_pulse);
        end
        step(7);
        total++;
        if (state !== 2'b11) begin
            bad++;
            $display("FAIL cooldown_end7: got s=%b want 11", state);
        end
        step(1);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL cooldown_end8: got s=%b want 00", state);
        end
        step(5);
        total++;
        if (state !== 2'b00 || angle_sel !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_cd: got s=%b a=%b want s=00 a=1", state, angle_sel);
        end
    endtask

    task automatic test_timeout();
        int open_cnt;
        soil_dry_raw = 1'b1;
        step(7);
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL to_enter: got s=%b want 01", state);
        end
        open_cnt = (angle_sel === 1'b0) ? 1 : 0;
        for (int i = 0; i < 25 && angle_sel === 1'b0; i++) begin
            step(1);
            if (angle_sel === 1'b0) open_cnt++;
        end
        total++;
        if (open_cnt != 20) begin
            bad++;
            $display("FAIL open_cycles: got %0d want 20", open_cnt);
        end
        total++;
        if (state !== 2'b11 || timeout_pulse !== 1'b1) begin
            bad++;
            $display("FAIL to_pulse: got s=%b t=%b want s=11 t=1", state, timeout_pulse);
        end
        step(1);
        total++;
        if (timeout_pulse !== 1'b0 || state !== 2'b11) begin
            bad++;
            $display("FAIL to_single: got t=%b s=%b want t=0 s=11", timeout_pulse, state);
        end
        step(6);
        total++;
        if (state !== 2'b11) begin
            bad++;
            $display("FAIL to_cd7: got s=%b want 11", state);
        end
        step(1);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL to_idle: got s=%b want 00", state);
        end
        step(1);
        total++;
        if (state !== 2'b01 || angle_sel !== 1'b0) begin
            bad++;
            $display("FAIL to_rewater: got s=%b a=%b want s=01 a=0", state, angle_sel);
        end
    endtask

    task automatic test_rain();
        rain_raw = 1'b1;
        step(6);
        total++;
        if (rain_det !== 1'b1 || state !== 2'b01) begin
            bad++;
            $display("FAIL rain_db6: got r=%b s=%b want r=1 s=01", rain_det, state);
        end
        step(1);
        total++;
        if (state !== 2'b10 || angle_sel !== 1'b1 || watering !== 1'b0) begin
            bad++;
            $display("FAIL rain_hold7: got s=%b a=%b w=%b want s=10 a=1 w=0", state, angle_sel, watering);
        end
        step(30);
        total++;
        if (state !== 2'b10 || angle_sel !== 1'b1) begin
            bad++;
            $display("FAIL rain_held30: got s=%b a=%b want s=10 a=1", state, angle_sel);
        end
        rain_raw = 1'b0;
        step(5);
        total++;
        if (rain_det !== 1'b1) begin
            bad++;
            $display("FAIL rain_clear5: got r=%b want 1", rain_det);
        end
        step(1);
        total++;
        if (rain_det !== 1'b0 || state !== 2'b10) begin
            bad++;
            $display("FAIL rain_clear6: got r=%b s=%b want r=0 s=10", rain_det, state);
        end
        step(9);
        total++;
        if (state !== 2'b10) begin
            bad++;
            $display("FAIL rh_count9: got s=%b want 10", state);
        end
        step(1);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL rh_idle: got s=%b want 00", state);
        end
        step(1);
        total++;
        if (state !== 2'b01 || angle_sel !== 1'b0) begin
            bad++;
            $display("FAIL rh_rewater: got s=%b a=%b want s=01 a=0", state, angle_sel);
        end
    endtask

    task automatic test_glitch();
        rain_raw = 1'b1;
        step(3);
        rain_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            total++;
            if (rain_det !== 1'b0 || angle_sel !== 1'b0) begin
                bad++;
                $display("FAIL glitch cyc%0d: got r=%b a=%b want r=0 a=0", i, rain_det, angle_sel);
            end
        end
    endtask

    task automatic test_async_reset();
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL ar_pre: got s=%b want 01", state);
        end
        #3 reset_n = 1'b0;
        #1;
        total++;
        if (angle_sel !== 1'b1 || state !== 2'b00 || watering !== 1'b0) begin
            bad++;
            $display("FAIL ar_immediate: got a=%b s=%b w=%b want a=1 s=00 w=0", angle_sel, state, watering);
        end
        step(2);
        reset_n = 1'b1;
        step(6);
        total++;
        if (state !== 2'b00 || angle_sel !== 1'b1) begin
            bad++;
            $display("FAIL ar_latency6: got s=%b a=%b want s=00 a=1", state, angle_sel);
        end
        step(1);
        total++;
        if (state !== 2'b01 || angle_sel !== 1'b0) begin
            bad++;
            $display("FAIL ar_latency7: got s=%b a=%b want s=01 a=0", state, angle_sel);
        end
    endtask

    initial begin
        test_reset();
        test_water_dry();
        test_timeout();
        test_rain();
        test_glitch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
